if_fetch: RTL and testbench

Instruction fetch stage of the primus RISC-V core, sitting directly upstream of the decode stage and its register file. It holds the program counter and issues in-order 4-byte fetch requests to the instruction memory over a req/gnt/rvalid handshake. It buffers returned instructions in a small FIFO and hands {instruction, PC} pairs to decode over a valid/ready interface. A redirect input from execute/branch resolution flushes the buffer, discards in-flight responses and restarts fetch at a new PC.

---
 rtl/if_fetch.sv | 114 +++++++++++
 tb/tb_if_fetch.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: holds the PC, issues in-order 4-byte fetches over req/gnt/rvalid
// and buffers returned words in a small FIFO that feeds decode over valid/ready.
module if_fetch #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_W  = CW'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [31:0]     instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] ipc_q   [FIFO_DEPTH];

  logic            pop;
  logic            grant;
  logic            push;
  logic            drop_resp;
  logic [CW:0]     committed;
  logic [XLEN-1:0] resp_pc;
  logic            unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc_i[1:0];

  assign id_valid_o  = (count_q != '0) & !redirect_i;
  assign pop         = id_valid_o & id_ready_i;
  assign id_instr_o  = instr_q[rd_ptr_q];
  assign id_pc_o     = ipc_q[rd_ptr_q];
  assign imem_addr_o = pc_q;

  // Buffer slots already spoken for; a new request is only allowed if its word has a home.
  assign committed  = {1'b0, count_q} + {1'b0, outstanding_q} - (CW+1)'(pop);
  assign imem_req_o = !rst_i & !redirect_i & (committed < DEPTH_W);
  assign grant      = imem_req_o & imem_gnt_i;

  assign drop_resp = imem_rvalid_i & (drop_q != '0);
  assign push      = imem_rvalid_i & !redirect_i & (drop_q == '0);

  // Live (non-dropped) requests were issued consecutively and end just below pc_q,
  // so the oldest of them, which is the one now responding, sits that many words back.
  assign resp_pc = pc_q - (XLEN'(outstanding_q - drop_q) << 2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else begin
      outstanding_q <= outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
      if (redirect_i) begin
        pc_q     <= {redirect_pc_i[XLEN-1:2], 2'b00};
        drop_q   <= outstanding_q - CW'(imem_rvalid_i);
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (grant) begin
          pc_q <= pc_q + XLEN'(4);
        end
        if (drop_resp) begin
          drop_q <= drop_q - CW'(1);
        end
        if (push) begin
          instr_q[wr_ptr_q] <= imem_rdata_i;
          ipc_q[wr_ptr_q]   <= resp_pc;
          wr_ptr_q          <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

`ifndef SYNTHESIS
  a_rvalid_credit: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> (outstanding_q != '0));
  a_push_not_full: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (count_q != FULL_W));
  a_gnt_with_req: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_gnt_i |-> imem_req_o);
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: in-order memory model plus an architectural model of which PC
// should be fetched next and which {pc, instr} decode should see next.
module tb_if_fetch;
  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          DEPTH    = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_instr_o;
  logic [63:0] id_pc_o;

  always #5 clk_i = ~clk_i;

  if_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_instr_o(id_instr_o), .id_pc_o(id_pc_o)
  );

  int vectors = 0;
  int miscompares = 0;

  int ready_pct = 100, gnt_pct = 100, rv_pct = 100, lat = 1;
  logic        drv_redirect = 1'b0;
  logic [63:0] drv_rpc = '0;
  logic [31:0] key = '0;

  logic [63:0] mq_addr[$];
  int          mq_due[$];
  int          cyc;
  logic [63:0] exp_fetch, exp_dec;

  logic        obs_req, obs_gnt, obs_rvalid, obs_valid, obs_pop, obs_redirect;
  logic [63:0] obs_addr, obs_pc;
  logic [31:0] obs_instr;
  logic [63:0] exp_grant_addr, exp_pop_pc;
  logic [31:0] exp_pop_instr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ key;
  endfunction

  task automatic model_reset();
    mq_addr.delete();
    mq_due.delete();
    exp_fetch = RESET_PC;
    exp_dec   = RESET_PC;
    cyc       = 0;
  endtask

  task automatic do_reset();
    imem_gnt_i = 0; imem_rvalid_i = 0; redirect_i = 0; id_ready_i = 0; drv_redirect = 0;
    rst_i = 1;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 0;
    model_reset();
  endtask

  // One clock: drive memory/decode/redirect, sample outputs, advance the models.
  task automatic cycle();
    imem_rvalid_i = 0;
    imem_rdata_i  = '0;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc && int'($urandom_range(99)) < rv_pct) begin
      imem_rvalid_i = 1;
      imem_rdata_i  = mem_word(mq_addr[0]);
    end
    redirect_i    = drv_redirect;
    redirect_pc_i = drv_redirect ? drv_rpc : {$urandom, $urandom};
    id_ready_i    = int'($urandom_range(99)) < ready_pct;
    #1;
    imem_gnt_i = imem_req_o && (int'($urandom_range(99)) < gnt_pct);
    #1;
    obs_req = imem_req_o; obs_addr = imem_addr_o; obs_gnt = imem_gnt_i;
    obs_rvalid = imem_rvalid_i; obs_valid = id_valid_o; obs_pc = id_pc_o;
    obs_instr = id_instr_o; obs_pop = id_valid_o && id_ready_i; obs_redirect = redirect_i;
    exp_grant_addr = exp_fetch;
    exp_pop_pc     = exp_dec;
    exp_pop_instr  = mem_word(exp_dec);
    if (drv_redirect) begin
      exp_fetch = {drv_rpc[63:2], 2'b00};
      exp_dec   = {drv_rpc[63:2], 2'b00};
    end else begin
      if (obs_req && obs_gnt) exp_fetch = exp_fetch + 64'd4;
      if (obs_pop) exp_dec = exp_dec + 64'd4;
    end
    @(posedge clk_i); #1;
    if (obs_rvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (obs_req && obs_gnt) begin
      mq_addr.push_back(obs_addr);
      mq_due.push_back(cyc + lat);
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst_i = 1;
    @(posedge clk_i); @(posedge clk_i); #1;
    vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
    vectors++; if (id_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", id_valid_o); end
    vectors++; if (imem_addr_o !== RESET_PC) begin miscompares++; $display("FAIL reset_addr got=%h exp=%h", imem_addr_o, RESET_PC); end
    vectors++; if (id_instr_o !== 32'h0) begin miscompares++; $display("FAIL reset_instr got=%h exp=0", id_instr_o); end
    vectors++; if (id_pc_o !== 64'h0) begin miscompares++; $display("FAIL reset_pc got=%h exp=0", id_pc_o); end
    rst_i = 0;
    model_reset();
  endtask

  task automatic test_stream();
    logic [63:0] e;
    key = '0; lat = 1; ready_pct = 100; gnt_pct = 100; rv_pct = 100;
    for (int c = 0; c < 12; c++) begin
      cycle();
      e = RESET_PC + 64'(4 * c);
      vectors++; if (obs_req !== 1'b1 || obs_addr !== e) begin
        miscompares++; $display("FAIL stream_req c=%0d got=%b/%h exp=1/%h", c, obs_req, obs_addr, e);
      end
      if (c >= 2) begin
        e = RESET_PC + 64'(4 * (c - 2));
        vectors++; if (obs_valid !== 1'b1 || obs_pc !== e || obs_instr !== e[31:0]) begin
          miscompares++; $display("FAIL stream_dec c=%0d got=%b/%h/%h exp=1/%h/%h", c, obs_valid, obs_pc, obs_instr, e, e[31:0]);
        end
      end else begin
        vectors++; if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL stream_early c=%0d got=%b exp=0", c, obs_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    int npop = 0;
    logic [63:0] pops[2];
    logic [63:0] first_ga = '1;
    do_reset();
    ready_pct = 0; lat = 1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (obs_req && obs_gnt) grants++;
      if (c >= 2) begin
        vectors++; if (obs_valid !== 1'b1 || obs_pc !== RESET_PC) begin
          miscompares++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, obs_valid, obs_pc, RESET_PC);
        end
      end
    end
    vectors++; if (grants !== 2) begin miscompares++; $display("FAIL bp_grants got=%0d exp=2", grants); end
    ready_pct = 100;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (obs_pop && npop < 2) begin pops[npop] = obs_pc; npop++; end
      if (obs_req && obs_gnt && first_ga === '1) first_ga = obs_addr;
    end
    vectors++; if (npop !== 2 || pops[0] !== RESET_PC || pops[1] !== RESET_PC + 64'd4) begin
      miscompares++; $display("FAIL bp_release got=%0d/%h/%h exp=2/%h/%h", npop, pops[0], pops[1], RESET_PC, RESET_PC + 64'd4);
    end
    vectors++; if (first_ga !== RESET_PC + 64'd8) begin
      miscompares++; $display("FAIL bp_resume got=%h exp=%h", first_ga, RESET_PC + 64'd8);
    end
  endtask

  task automatic check_pop_stream(input string name, input int n, output logic [63:0] first_pc);
    first_pc = '1;
    for (int c = 0; c < n; c++) begin
      cycle();
      if (obs_pop) begin
        if (first_pc === '1) first_pc = obs_pc;
        vectors++; if (obs_pc !== exp_pop_pc || obs_instr !== exp_pop_instr) begin
          miscompares++; $display("FAIL %s_pop got=%h/%h exp=%h/%h", name, obs_pc, obs_instr, exp_pop_pc, exp_pop_instr);
        end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    logic [63:0] first_pc;
    int c = 0;
    do_reset();
    lat = 3; ready_pct = 100;
    while (mq_addr.size() < 2 && c < 10) begin cycle(); c++; end
    vectors++; if (mq_addr.size() !== 2) begin miscompares++; $display("FAIL rdi_outstanding got=%0d exp=2", mq_addr.size()); end
    drv_redirect = 1; drv_rpc = 64'h8000_0100;
    cycle();
    drv_redirect = 0;
    vectors++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
      miscompares++; $display("FAIL rdi_quiet got=%b/%b exp=0/0", obs_req, obs_valid);
    end
    check_pop_stream("rdi", 20, first_pc);
    vectors++; if (first_pc !== 64'h8000_0100) begin miscompares++; $display("FAIL rdi_first got=%h exp=80000100", first_pc); end
  endtask

  task automatic test_redirect_full();
    logic [63:0] first_pc;
    do_reset();
    lat = 2; ready_pct = 0;
    for (int c = 0; c < 3; c++) cycle();
    drv_redirect = 1; drv_rpc = 64'h8000_0180;
    cycle();
    vectors++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
      miscompares++; $display("FAIL rdf_first_quiet got=%b/%b exp=0/0", obs_req, obs_valid);
    end
    drv_rpc = 64'h200; ready_pct = 100;
    cycle();
    drv_redirect = 0;
    vectors++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
      miscompares++; $display("FAIL rdf_second_quiet got=%b/%b exp=0/0", obs_req, obs_valid);
    end
    check_pop_stream("rdf", 20, first_pc);
    vectors++; if (first_pc !== 64'h200) begin miscompares++; $display("FAIL rdf_first got=%h exp=200", first_pc); end
    vectors++; if (dut.drop_q !== '0) begin miscompares++; $display("FAIL rdf_drop got=%0d exp=0", dut.drop_q); end
  endtask

  task automatic test_misaligned();
    do_reset();
    lat = 1; ready_pct = 100;
    for (int c = 0; c < 4; c++) cycle();
    drv_redirect = 1; drv_rpc = 64'h8000_0102;
    cycle();
    drv_redirect = 0;
    vectors++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
      miscompares++; $display("FAIL mis_quiet got=%b/%b exp=0/0", obs_req, obs_valid);
    end
    cycle();
    vectors++; if (obs_req !== 1'b1 || obs_addr !== 64'h8000_0100 || obs_valid !== 1'b0) begin
      miscompares++; $display("FAIL mis_n1 got=%b/%h/%b exp=1/80000100/0", obs_req, obs_addr, obs_valid);
    end
    cycle();
    vectors++; if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL mis_n2 got=%b exp=0", obs_valid); end
    cycle();
    vectors++; if (obs_valid !== 1'b1 || obs_pc !== 64'h8000_0100 || obs_instr !== exp_pop_instr) begin
      miscompares++; $display("FAIL mis_n3 got=%b/%h/%h exp=1/80000100/%h", obs_valid, obs_pc, obs_instr, exp_pop_instr);
    end
  endtask

  task automatic test_stall_reset();
    do_reset();
    lat = 1; ready_pct = 100; gnt_pct = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      vectors++; if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
        miscompares++; $display("FAIL stall c=%0d got=%b/%h exp=1/%h", c, obs_req, obs_addr, RESET_PC);
      end
    end
    gnt_pct = 100;
    for (int c = 0; c < 4; c++) cycle();
    imem_gnt_i = 0; imem_rvalid_i = 0; id_ready_i = 0;
    #2 rst_i = 1;
    #1;
    vectors++; if (imem_req_o !== 1'b0 || id_valid_o !== 1'b0 || imem_addr_o !== RESET_PC || id_instr_o !== 32'h0 || id_pc_o !== 64'h0) begin
      miscompares++; $display("FAIL async_rst got=%b/%b/%h/%h/%h exp=0/0/%h/0/0", imem_req_o, id_valid_o, imem_addr_o, id_instr_o, id_pc_o, RESET_PC);
    end
    @(posedge clk_i); #1;
    rst_i = 0;
    model_reset();
    cycle();
    vectors++; if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
      miscompares++; $display("FAIL rst_restart got=%b/%h exp=1/%h", obs_req, obs_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    key = $urandom;
    ready_pct = 70; gnt_pct = 70; rv_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      lat = $urandom_range(1, 4);
      drv_redirect = ($urandom_range(99) < 4);
      drv_rpc = {$urandom, $urandom};
      cycle();
      if (obs_redirect) begin
        vectors++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
          miscompares++; $display("FAIL rnd_redirect c=%0d got=%b/%b exp=0/0", c, obs_req, obs_valid);
        end
      end
      if (obs_req && obs_gnt) begin
        vectors++; if (obs_addr !== exp_grant_addr) begin
          miscompares++; $display("FAIL rnd_fetch c=%0d got=%h exp=%h", c, obs_addr, exp_grant_addr);
        end
      end
      if (obs_pop) begin
        vectors++; if (obs_pc !== exp_pop_pc || obs_instr !== exp_pop_instr) begin
          miscompares++; $display("FAIL rnd_pop c=%0d got=%h/%h exp=%h/%h", c, obs_pc, obs_instr, exp_pop_pc, exp_pop_instr);
        end
      end
      vectors++; if (mq_addr.size() > DEPTH) begin
        miscompares++; $display("FAIL rnd_credit c=%0d got=%0d exp<=%0d", c, mq_addr.size(), DEPTH);
      end
    end
    drv_redirect = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_full();
    test_misaligned();
    test_stall_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
